// File: rtl/link_pkg.sv
// Shared types and constants for the host SPI link scheduler.
package link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE0,
    PRE1,
    XFER,
    GAP
  } link_state_t;

  typedef enum logic {
    TGT_VIDEO,
    TGT_AUDIO
  } link_target_t;

  localparam logic [7:0] PREAMBLE0 = 8'h00;
  localparam logic [7:0] PREAMBLE1 = 8'hFF;

endpackage

// File: rtl/link_arbiter.sv
// Video/audio grant decision for the SPI link, with the audio starvation guard counter.
module link_arbiter
  import link_pkg::*;
#(
  parameter int unsigned AUDIO_LOW     = 32,
  parameter int unsigned MAX_AUDIO_RUN = 3
) (
  input  logic         CLK_40,
  input  logic         reset_n,
  input  logic         arb_en,
  input  logic         video_req,
  input  logic [7:0]   audio_fill,
  output logic         grant,
  output link_target_t grant_tgt
);

  logic [7:0] audio_run_q, audio_run_d;
  logic       audio_need;

  assign audio_need = (audio_fill <= 8'(AUDIO_LOW));

  always_comb begin
    grant       = 1'b0;
    grant_tgt   = TGT_VIDEO;
    audio_run_d = audio_run_q;
    if (arb_en) begin
      // Video wins once audio has held the link MAX_AUDIO_RUN times in a row.
      if (audio_need && video_req && (audio_run_q == 8'(MAX_AUDIO_RUN))) begin
        grant     = 1'b1;
        grant_tgt = TGT_VIDEO;
      end else if (audio_need) begin
        grant     = 1'b1;
        grant_tgt = TGT_AUDIO;
      end else if (video_req) begin
        grant     = 1'b1;
        grant_tgt = TGT_VIDEO;
      end
    end
    if (grant) begin
      if (grant_tgt == TGT_VIDEO) begin
        audio_run_d = 8'd0;
      end else if (video_req) begin
        audio_run_d = audio_run_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      audio_run_q <= 8'd0;
    end else begin
      audio_run_q <= audio_run_d;
    end
  end

endmodule

// File: rtl/link_scheduler.sv
// Sequences the host SPI link between the video write bank and the audio FIFO:
// preamble check, payload steering with running address, byte timeout and inter-transfer gap.
module link_scheduler
  import link_pkg::*;
#(
  parameter int unsigned VIDEO_BYTES    = 90,
  parameter int unsigned AUDIO_BYTES    = 64,
  parameter int unsigned AUDIO_LOW      = 32,
  parameter int unsigned MAX_AUDIO_RUN  = 3,
  parameter int unsigned GAP_CYCLES     = 40,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned ADDR_W         = 16
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              video_req,
  input  logic [7:0]        audio_fill,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte,
  output logic              chip_select,
  output logic              wr_en_video,
  output logic              wr_en_audio,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              video_done,
  output logic              audio_done,
  output logic              sync_err,
  output logic              timeout_err
);

  link_state_t       state_q, state_d;
  link_target_t      tgt_q, tgt_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              wr_en_video_q, wr_en_video_d;
  logic              wr_en_audio_q, wr_en_audio_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              video_done_q, video_done_d;
  logic              audio_done_q, audio_done_d;
  logic              sync_err_q, sync_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic              arb_en;
  logic              grant;
  link_target_t      grant_tgt;
  logic [ADDR_W-1:0] last_idx;
  logic              go_gap;

  assign arb_en   = (state_q == IDLE);
  assign last_idx = (tgt_q == TGT_VIDEO) ? ADDR_W'(VIDEO_BYTES - 1) : ADDR_W'(AUDIO_BYTES - 1);

  link_arbiter #(
    .AUDIO_LOW    (AUDIO_LOW),
    .MAX_AUDIO_RUN(MAX_AUDIO_RUN)
  ) u_arb (
    .CLK_40    (CLK_40),
    .reset_n   (reset_n),
    .arb_en    (arb_en),
    .video_req (video_req),
    .audio_fill(audio_fill),
    .grant     (grant),
    .grant_tgt (grant_tgt)
  );

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    count_d       = count_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    cs_d          = cs_q;
    wr_en_video_d = 1'b0;
    wr_en_audio_d = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    video_done_d  = 1'b0;
    audio_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    go_gap        = 1'b0;

    // Byte watchdog shared by every selected state.
    if ((state_q == PRE0) || (state_q == PRE1) || (state_q == XFER)) begin
      if (rx_byte_valid) begin
        timer_d = 32'd0;
      end else if (timer_q == TIMEOUT_CYCLES - 1) begin
        timeout_err_d = 1'b1;
        go_gap        = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant) begin
          tgt_d     = grant_tgt;
          cs_d      = 1'b0;
          wr_addr_d = '0;
          count_d   = '0;
          timer_d   = 32'd0;
          state_d   = PRE0;
        end
      end
      PRE0: begin
        if (rx_byte_valid) begin
          if (rx_byte == PREAMBLE0) begin
            state_d = PRE1;
          end else begin
            sync_err_d = 1'b1;
            go_gap     = 1'b1;
          end
        end
      end
      PRE1: begin
        if (rx_byte_valid) begin
          if (rx_byte == PREAMBLE1) begin
            count_d = '0;
            state_d = XFER;
          end else begin
            sync_err_d = 1'b1;
            go_gap     = 1'b1;
          end
        end
      end
      XFER: begin
        if (rx_byte_valid) begin
          wr_en_video_d = (tgt_q == TGT_VIDEO);
          wr_en_audio_d = (tgt_q == TGT_AUDIO);
          wr_addr_d     = count_q;
          wr_data_d     = rx_byte;
          count_d       = count_q + ADDR_W'(1);
          if (count_q == last_idx) begin
            video_done_d = (tgt_q == TGT_VIDEO);
            audio_done_d = (tgt_q == TGT_AUDIO);
            go_gap       = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_CYCLES - 1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_gap) begin
      state_d = GAP;
      cs_d    = 1'b1;
      gap_d   = 32'd0;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tgt_q         <= TGT_VIDEO;
      count_q       <= '0;
      timer_q       <= 32'd0;
      gap_q         <= 32'd0;
      cs_q          <= 1'b1;
      wr_en_video_q <= 1'b0;
      wr_en_audio_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'd0;
      video_done_q  <= 1'b0;
      audio_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      cs_q          <= cs_d;
      wr_en_video_q <= wr_en_video_d;
      wr_en_audio_q <= wr_en_audio_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      video_done_q  <= video_done_d;
      audio_done_q  <= audio_done_d;
      sync_err_q    <= sync_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign chip_select = cs_q;
  assign wr_en_video = wr_en_video_q;
  assign wr_en_audio = wr_en_audio_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign video_done  = video_done_q;
  assign audio_done  = audio_done_q;
  assign sync_err    = sync_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_link_scheduler.sv
// Self-checking bench for link_scheduler: arbitration table, payload scoreboard, error corners.
module tb_link_scheduler;

  localparam int VB   = 90;
  localparam int AB   = 64;
  localparam int GAPC = 40;
  localparam int TO   = 40000;

  logic        CLK_40 = 1'b0;
  logic        reset_n = 1'b0;
  logic        video_req = 1'b0;
  logic [7:0]  audio_fill = 8'd200;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        chip_select, wr_en_video, wr_en_audio;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        video_done, audio_done, sync_err, timeout_err;

  link_scheduler dut (
    .CLK_40       (CLK_40),
    .reset_n      (reset_n),
    .video_req    (video_req),
    .audio_fill   (audio_fill),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .chip_select  (chip_select),
    .wr_en_video  (wr_en_video),
    .wr_en_audio  (wr_en_audio),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .video_done   (video_done),
    .audio_done   (audio_done),
    .sync_err     (sync_err),
    .timeout_err  (timeout_err)
  );

  always #5 CLK_40 = ~CLK_40;

  typedef struct packed {
    logic        video;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic       vr;
    logic [7:0] fill;
    logic       exp_video;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  done_cyc = 0;
  int  vdone_cnt = 0, adone_cnt = 0, sync_cnt = 0, to_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK_40) cyc <= cyc + 1;

  // Scoreboard monitor: every write strobe must match the next expected payload byte.
  always @(negedge CLK_40) begin
    if (reset_n) begin
      if (wr_en_video || wr_en_audio) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", wr_addr,
                   wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_target", {30'd0, wr_en_video, wr_en_audio}, e.video ? 32'd2 : 32'd1);
          check("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
          check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end
      end
      if (video_done) begin
        vdone_cnt++;
        check("vdone_on_last", {15'd0, wr_en_video, wr_addr}, {15'd0, 1'b1, 16'(VB - 1)});
      end
      if (audio_done) begin
        adone_cnt++;
        check("adone_on_last", {15'd0, wr_en_audio, wr_addr}, {15'd0, 1'b1, 16'(AB - 1)});
      end
      if (sync_err) sync_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  task automatic drive(input logic [7:0] b);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    @(negedge CLK_40);
    rx_byte_valid = 1'b0;
  endtask

  // Gap is GAP_CYCLES in GAP plus one IDLE arbitration cycle before select drops.
  task automatic wait_cs_low(input bit chk_gap);
    for (int k = 0; k < 400; k++) begin
      if (!chip_select) break;
      @(negedge CLK_40);
    end
    if (chip_select) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_wait: got chip_select 1, expected 0 within 400 cycles");
    end else if (chk_gap) begin
      check("gap_len", 32'(cyc - done_cyc), 32'(GAPC + 1));
    end
  endtask

  task automatic run_xfer(input logic vr, input logic [7:0] fill, input logic exp_video,
                          input bit chk_gap);
    int         n;
    logic [7:0] d;
    video_req  = vr;
    audio_fill = fill;
    wait_cs_low(chk_gap);
    drive(8'h00);
    drive(8'hFF);
    n = exp_video ? VB : AB;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      exp_q.push_back({exp_video, 16'(i), d});
      drive(d);
    end
    for (int k = 0; k < 5; k++) begin
      if (video_done || audio_done) break;
      @(negedge CLK_40);
    end
    check("done_video", {31'd0, video_done}, {31'd0, exp_video});
    check("done_audio", {31'd0, audio_done}, {31'd0, ~exp_video});
    check("done_cs_high", {31'd0, chip_select}, 32'd1);
    done_cyc = cyc;
  endtask

  vec_t vecs[12];

  initial begin
    int b, vd, ad;
    // Arbitration sequence: run counter starts at 0; fill 32 is the inclusive low boundary.
    vecs[0]  = '{1'b1, 8'd200, 1'b1};
    vecs[1]  = '{1'b0, 8'd10,  1'b0};
    vecs[2]  = '{1'b0, 8'd32,  1'b0};
    vecs[3]  = '{1'b1, 8'd33,  1'b1};
    vecs[4]  = '{1'b1, 8'd10,  1'b0};
    vecs[5]  = '{1'b1, 8'd10,  1'b0};
    vecs[6]  = '{1'b1, 8'd10,  1'b0};
    vecs[7]  = '{1'b1, 8'd10,  1'b1};
    vecs[8]  = '{1'b1, 8'd10,  1'b0};
    vecs[9]  = '{1'b1, 8'd10,  1'b0};
    vecs[10] = '{1'b1, 8'd10,  1'b0};
    vecs[11] = '{1'b1, 8'd10,  1'b1};

    repeat (2) @(negedge CLK_40);
    check("rst_cs", {31'd0, chip_select}, 32'd1);
    check("rst_wr_en", {30'd0, wr_en_video, wr_en_audio}, 32'd0);
    check("rst_addr", {16'd0, wr_addr}, 32'd0);
    check("rst_data", {24'd0, wr_data}, 32'd0);
    check("rst_pulses", {28'd0, video_done, audio_done, sync_err, timeout_err}, 32'd0);
    reset_n = 1'b1;

    // Bytes while idle with nothing requested are ignored.
    video_req  = 1'b0;
    audio_fill = 8'd200;
    @(negedge CLK_40);
    drive(8'h00);
    drive(8'h7E);
    drive(8'h55);
    repeat (3) @(negedge CLK_40);
    check("idle_cs", {31'd0, chip_select}, 32'd1);
    check("idle_no_err", 32'(sync_cnt + to_cnt), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_xfer(vecs[i].vr, vecs[i].fill, vecs[i].exp_video, i != 0);
    end

    // Bad second preamble byte.
    video_req  = 1'b0;
    audio_fill = 8'd10;
    wait_cs_low(1'b1);
    drive(8'h00);
    drive(8'h7E);
    check("sync_err", {31'd0, sync_err}, 32'd1);
    check("sync_cs", {31'd0, chip_select}, 32'd1);
    done_cyc = cyc;
    run_xfer(1'b0, 8'd10, 1'b0, 1'b1);

    // Stall mid-payload until the watchdog fires, then retry from address 0.
    video_req  = 1'b1;
    audio_fill = 8'd200;
    wait_cs_low(1'b1);
    drive(8'h00);
    drive(8'hFF);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      exp_q.push_back({1'b1, 16'(i), d});
      drive(d);
    end
    b  = cyc;
    vd = vdone_cnt;
    ad = adone_cnt;
    for (int k = 0; k < TO + 50; k++) begin
      if (timeout_err) break;
      @(negedge CLK_40);
    end
    check("timeout_delay", 32'(cyc - b), 32'(TO));
    check("timeout_cs", {31'd0, chip_select}, 32'd1);
    check("timeout_no_done", 32'(vdone_cnt + adone_cnt), 32'(vd + ad));
    done_cyc = cyc;
    run_xfer(1'b1, 8'd200, 1'b1, 1'b1);

    // Asynchronous reset while writing address 45.
    wait_cs_low(1'b1);
    drive(8'h00);
    drive(8'hFF);
    for (int i = 0; i < 46; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      exp_q.push_back({1'b1, 16'(i), d});
      drive(d);
    end
    check("pre_rst_addr", {16'd0, wr_addr}, 32'd45);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", {31'd0, chip_select}, 32'd1);
    check("mid_rst_wr_en", {30'd0, wr_en_video, wr_en_audio}, 32'd0);
    check("mid_rst_addr", {16'd0, wr_addr}, 32'd0);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    @(negedge CLK_40);
    reset_n = 1'b1;
    run_xfer(1'b1, 8'd200, 1'b1, 1'b0);

    video_req  = 1'b0;
    audio_fill = 8'd200;
    repeat (5) @(negedge CLK_40);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("final_vdone", 32'(vdone_cnt), 32'd6);
    check("final_adone", 32'(adone_cnt), 32'd9);
    check("final_sync", 32'(sync_cnt), 32'd1);
    check("final_timeout", 32'(to_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
